// File: rtl/loop_issue_ctrl_pkg.sv
// Shared types for the loop iteration issuer: FSM state encoding and 32-bit count type.
package loop_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [31:0] cnt_t;

endpackage

// File: rtl/interval_counter.sv
// Free-running 0..PERIOD-1 counter; wrap is combinational and asserts on the last count of a period.
// clear has priority over en; a cycle with en=0 freezes the count and masks wrap.
module interval_counter
  import loop_issue_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic wrap
);

  localparam cnt_t LAST = cnt_t'(PERIOD - 32'd1);

  cnt_t count;

  assign wrap = en && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/loop_issue_ctrl.sv
// Pipelined-loop issuer: on go, one issue pulse every II cycles for TRIP_COUNT iterations, then done after LATENCY.
// Optional freeze via `stall` when LOOP_ISSUE_CTRL_STALL_EN is defined; otherwise stall is ignored.
module loop_issue_ctrl
  import loop_issue_ctrl_pkg::*;
#(
  parameter int unsigned II         = 1,
  parameter int unsigned TRIP_COUNT = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        stall,
  output logic        issue,
  output logic [31:0] iter_idx,
  output logic        busy,
  output logic        done
);

  if (II == 0) begin : g_bad_ii
    $error("loop_issue_ctrl: II must be >= 1");
  end

  localparam cnt_t        LAST_IDX   = cnt_t'(TRIP_COUNT - 32'd1);
  localparam int unsigned DRAIN_PER  = (LATENCY == 0) ? 1 : LATENCY;

  state_e state;
  logic   run_en;
  logic   ii_wrap;
  logic   drain_wrap;
  cnt_t   next_idx;

`ifdef LOOP_ISSUE_CTRL_STALL_EN
  assign run_en = !stall;
`else
  logic stall_unused;
  assign stall_unused = stall;
  assign run_en       = 1'b1;
`endif

  assign next_idx = iter_idx + 32'd1;

  interval_counter #(.PERIOD(II)) u_ii_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != ISSUE),
    .en    (run_en),
    .wrap  (ii_wrap)
  );

  interval_counter #(.PERIOD(DRAIN_PER)) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != DRAIN),
    .en    (run_en),
    .wrap  (drain_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      issue    <= 1'b0;
      iter_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      issue <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // busy still high here means this is the done cycle: go is ignored
          if (busy) begin
            busy <= 1'b0;
          end else if (go) begin
            if (TRIP_COUNT == 0) begin
              done <= 1'b1;
            end else begin
              issue    <= 1'b1;
              iter_idx <= '0;
              busy     <= 1'b1;
              if (TRIP_COUNT == 1) begin
                if (LATENCY == 0) done  <= 1'b1;
                else              state <= DRAIN;
              end else begin
                state <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (ii_wrap) begin
            issue    <= 1'b1;
            iter_idx <= next_idx;
            if (next_idx == LAST_IDX) begin
              if (LATENCY == 0) begin
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_wrap) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
